// File: rtl/muldiv_sequencer_if.sv
// Request/result bundle between a requester and the multiply/divide sequencer.
// dz_err exists only when MULDIV_DIV0_TRAP_EN is defined.
interface muldiv_sequencer_if #(
   parameter int WIDTH = 32
);
   logic               start;
   logic               op;
   logic               signed_op;
   logic [WIDTH-1:0]   a_in;
   logic [WIDTH-1:0]   b_in;
   logic               busy;
   logic [2*WIDTH-1:0] z_out;
   logic               z_enable;
   logic               hi_en;
   logic               lo_en;
   logic               done;
`ifdef MULDIV_DIV0_TRAP_EN
   logic               dz_err;

   modport master (
      output start, op, signed_op, a_in, b_in,
      input  busy, z_out, z_enable, hi_en, lo_en, done, dz_err
   );
   modport slave (
      input  start, op, signed_op, a_in, b_in,
      output busy, z_out, z_enable, hi_en, lo_en, done, dz_err
   );
`else
   modport master (
      output start, op, signed_op, a_in, b_in,
      input  busy, z_out, z_enable, hi_en, lo_en, done
   );
   modport slave (
      input  start, op, signed_op, a_in, b_in,
      output busy, z_out, z_enable, hi_en, lo_en, done
   );
`endif
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiplier / restoring divider with Z, HI/LO write strobes.
// Define MULDIV_DIV0_TRAP_EN to trap divide-by-zero in a one-cycle ERR state.
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input logic               clock,
   input logic               clear_n,
   muldiv_sequencer_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_CALC = 3'd1;
   localparam logic [2:0] S_FIX  = 3'd2;
   localparam logic [2:0] S_WRZ  = 3'd3;
   localparam logic [2:0] S_WRHL = 3'd4;
   localparam logic [2:0] S_ERR  = 3'd5;

   logic [2:0]         state;
   logic [CW-1:0]      cnt;
   logic               op_q;
   logic               neg_a;
   logic               neg_b;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo;
   logic [2*WIDTH-1:0] z;

   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic               div0;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_sh;
   logic               div_ge;
   logic [WIDTH-1:0]   nxt_hi;
   logic [WIDTH-1:0]   nxt_lo;
   logic [2*WIDTH-1:0] res;

   always_comb begin
      a_neg = bus.signed_op & bus.a_in[WIDTH-1];
      b_neg = bus.signed_op & bus.b_in[WIDTH-1];
      a_mag = a_neg ? -bus.a_in : bus.a_in;
      b_mag = b_neg ? -bus.b_in : bus.b_in;
`ifdef MULDIV_DIV0_TRAP_EN
      div0  = bus.op & (bus.b_in == '0);
`else
      div0  = 1'b0;
`endif
   end

   // hi:lo is the product accumulator (multiply) or remainder:quotient (divide)
   always_comb begin
      mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
      div_sh  = {hi, lo[WIDTH-1]};
      div_ge  = div_sh >= {1'b0, b_q};
      if (op_q) begin
         nxt_hi = div_ge ? div_sh[WIDTH-1:0] - b_q : div_sh[WIDTH-1:0];
         nxt_lo = {lo[WIDTH-2:0], div_ge};
      end else begin
         nxt_hi = mul_sum[WIDTH:1];
         nxt_lo = {mul_sum[0], lo[WIDTH-1:1]};
      end
   end

   always_comb begin
      if (op_q)
         res = {(neg_a ? -hi : hi), ((neg_a ^ neg_b) ? -lo : lo)};
      else
         res = (neg_a ^ neg_b) ? -{hi, lo} : {hi, lo};
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         op_q  <= 1'b0;
         neg_a <= 1'b0;
         neg_b <= 1'b0;
         b_q   <= '0;
         hi    <= '0;
         lo    <= '0;
         z     <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (bus.start) begin
                  op_q  <= bus.op;
                  neg_a <= a_neg;
                  neg_b <= b_neg;
                  b_q   <= b_mag;
                  hi    <= '0;
                  lo    <= a_mag;
                  cnt   <= '0;
                  state <= div0 ? S_ERR : S_CALC;
               end
            end
            S_CALC: begin
               hi  <= nxt_hi;
               lo  <= nxt_lo;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1))
                  state <= S_FIX;
            end
            S_FIX: begin
               z     <= res;
               state <= S_WRZ;
            end
            S_WRZ:   state <= S_WRHL;
            S_WRHL:  state <= S_IDLE;
            S_ERR:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy     = state != S_IDLE;
   assign bus.z_out    = z;
   assign bus.z_enable = state == S_WRZ;
   assign bus.hi_en    = state == S_WRHL;
   assign bus.lo_en    = state == S_WRHL;
   assign bus.done     = (state == S_WRHL) | (state == S_ERR);
`ifdef MULDIV_DIV0_TRAP_EN
   assign bus.dz_err   = state == S_ERR;
`endif
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed vectors, decoupled monitor.
// Works with or without MULDIV_DIV0_TRAP_EN defined.
module tb_muldiv_sequencer;
   localparam int W = 32;
`ifdef MULDIV_DIV0_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   typedef struct {
      logic [63:0] z;
      int          t0;
      bit          err;
   } exp_t;

   logic        clock = 1'b0;
   logic        clear_n = 1'b0;
   int          cyc = 0;
   int          tests = 0;
   int          fails = 0;
   logic [63:0] last_z = '0;
   exp_t        q[$];

   muldiv_sequencer_if #(.WIDTH(W)) bus();
   muldiv_sequencer #(.WIDTH(W)) dut (
      .clock   (clock),
      .clear_n (clear_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_done(input exp_t e);
      chk("done_cycle", 64'(cyc - e.t0), 64'd34);
      chk("hi_lo_en", {62'd0, bus.hi_en, bus.lo_en}, 64'd3);
      chk("z_at_done", bus.z_out, e.z);
      last_z = e.z;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (clear_n) begin
            if (bus.z_enable) begin
               chk("z_enable_pending", 64'(q.size() > 0), 64'd1);
               if (q.size() > 0) begin
                  chk("z_enable_cycle", 64'(cyc - q[0].t0), 64'd33);
                  chk("z_at_wrz", bus.z_out, q[0].z);
               end
            end
            if (bus.done) begin
               chk("done_pending", 64'(q.size() > 0), 64'd1);
               if (q.size() > 0) begin
                  e = q.pop_front();
`ifdef MULDIV_DIV0_TRAP_EN
                  if (e.err) begin
                     chk("dz_err", 64'(bus.dz_err), 64'd1);
                     chk("err_cycle", 64'(cyc - e.t0), 64'd0);
                     chk("err_no_wr", {61'd0, bus.z_enable, bus.hi_en, bus.lo_en}, 64'd0);
                     chk("err_z_kept", bus.z_out, last_z);
                  end else begin
                     chk("no_dz_err", 64'(bus.dz_err), 64'd0);
                     chk_done(e);
                  end
`else
                  chk_done(e);
`endif
               end
            end
         end
      end
   end

   task automatic do_op(input bit nowait, input bit o, input bit s,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] z, input bit err);
      int t0;
      if (!nowait) @(negedge clock);
      bus.op = o;
      bus.signed_op = s;
      bus.a_in = a;
      bus.b_in = b;
      bus.start = 1'b1;
      @(posedge clock);
      #1;
      t0 = cyc;
      q.push_back('{z: z, t0: t0, err: err});
      bus.start = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clock);
         if (!bus.busy) break;
      end
      chk("idle_cycle", 64'(cyc - t0), err ? 64'd1 : 64'd35);
   endtask

   initial begin
      int t0;
      bus.start = 1'b0;
      bus.op = 1'b0;
      bus.signed_op = 1'b0;
      bus.a_in = '0;
      bus.b_in = '0;
      #1;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_z", bus.z_out, 64'd0);
      chk("rst_strobes", {60'd0, bus.z_enable, bus.hi_en, bus.lo_en, bus.done}, 64'd0);
`ifdef MULDIV_DIV0_TRAP_EN
      chk("rst_dz", 64'(bus.dz_err), 64'd0);
`endif
      repeat (2) @(negedge clock);
      clear_n = 1'b1;
      do_op(1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0);
      do_op(1'b0, 1'b0, 1'b1, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB, 1'b0);
      do_op(1'b0, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
      do_op(1'b0, 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0);
      do_op(1'b0, 1'b1, 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0);
      do_op(1'b0, 1'b1, 1'b0, 32'd5, 32'd0, 64'h00000005_FFFFFFFF, TRAP);
      do_op(1'b0, 1'b0, 1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0);
      do_op(1'b0, 1'b0, 1'b0, 32'h12345678, 32'h10, 64'h00000001_23456780, 1'b0);
      do_op(1'b0, 1'b1, 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0);

      // start held through a whole operation: second accept only from IDLE
      @(negedge clock);
      bus.op = 1'b0;
      bus.signed_op = 1'b0;
      bus.a_in = 32'd6;
      bus.b_in = 32'd7;
      bus.start = 1'b1;
      @(posedge clock);
      #1;
      t0 = cyc;
      q.push_back('{z: 64'd42, t0: t0, err: 1'b0});
      q.push_back('{z: 64'd42, t0: t0 + 36, err: 1'b0});
      repeat (35) @(posedge clock);
      @(negedge clock);
      chk("held_idle_c36", 64'(bus.busy), 64'd0);
      @(posedge clock);
      #1;
      chk("held_reaccept", 64'(bus.busy), 64'd1);
      bus.start = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clock);
         if (!bus.busy) break;
      end
      chk("held_idle2", 64'(cyc - t0), 64'd71);

      // reset mid-operation at cycle 10
      @(negedge clock);
      bus.a_in = 32'd3;
      bus.b_in = 32'd5;
      bus.start = 1'b1;
      @(posedge clock);
      #1;
      t0 = cyc;
      q.push_back('{z: 64'd15, t0: t0, err: 1'b0});
      bus.start = 1'b0;
      repeat (9) @(posedge clock);
      @(negedge clock);
      clear_n = 1'b0;
      #1;
      chk("abort_busy", 64'(bus.busy), 64'd0);
      chk("abort_strobes", {60'd0, bus.z_enable, bus.hi_en, bus.lo_en, bus.done}, 64'd0);
      chk("abort_z", bus.z_out, 64'd0);
      q.delete();
      last_z = '0;
      repeat (3) @(negedge clock);
      clear_n = 1'b1;
      do_op(1'b1, 1'b0, 1'b0, 32'd9, 32'd11, 64'd99, 1'b0);

      repeat (5) @(negedge clock);
      chk("queue_empty", 64'(q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
